// File: rtl/mux8_sched_pkg.sv
// Shared constants and state type for the eight-source round-robin scheduler.
package mux8_sched_pkg;
  localparam int unsigned N_SRC = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;
endpackage

// File: rtl/mux8_rr_sched_pick.sv
// Round-robin winner search: rotate req so ptr sits at bit 0, take the lowest set bit, rotate back.
module rr_pick8
  import mux8_sched_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [N_SRC-1:0] w_rot;
  logic [SEL_W-1:0] w_off;

  always_comb begin
    w_rot = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      w_rot[i] = req[SEL_W'(ptr + SEL_W'(i))];
    end
  end

  always_comb begin
    w_off = '0;
    for (int unsigned i = N_SRC; i > 0; i--) begin
      if (w_rot[i-1]) w_off = SEL_W'(i - 1);
    end
  end

  assign found = |req;
  assign idx   = ptr + w_off;

endmodule

// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler: grants one of eight sources, registers its word and streams
// up to BURST back-to-back beats over a valid/ready handshake before re-arbitrating.
module mux8_rr_sched
  import mux8_sched_pkg::*;
#(
  parameter int unsigned DW    = 3,
  parameter int unsigned BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_SRC-1:0]      req,
  input  logic [N_SRC*DW-1:0]   din,
  output logic [N_SRC-1:0]      ack,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  busy
);

  localparam int unsigned CW = $clog2(BURST + 1);

  state_t           r_state;
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] r_out_sel;
  logic [CW-1:0]    r_cnt;
  logic [DW-1:0]    r_out_data;
  logic             r_out_valid;

  logic             w_found;
  logic [SEL_W-1:0] w_idx;
  logic             w_accept;
  logic             w_more;
  logic             w_grant;
  logic [SEL_W-1:0] w_sel;
  logic [DW-1:0]    w_din_sel;

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  assign w_accept = r_out_valid && out_ready;
  assign w_more   = req[r_out_sel] && (r_cnt < CW'(BURST));

  // One grant decision drives both the ack strobe and the capture, so they cannot disagree.
  always_comb begin
    w_grant = 1'b0;
    w_sel   = r_out_sel;
    case (r_state)
      IDLE: begin
        w_grant = w_found;
        w_sel   = w_idx;
      end
      XFER: begin
        w_grant = w_accept && w_more;
      end
      default: begin
        w_grant = 1'b0;
      end
    endcase
  end

  assign w_din_sel = din[w_sel*DW +: DW];
  assign ack       = (rst_n && w_grant) ? (N_SRC'(1) << w_sel) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_out_data  <= w_din_sel;
            r_out_sel   <= w_sel;
            r_out_valid <= 1'b1;
            r_cnt       <= CW'(1);
            r_state     <= XFER;
          end
        end
        XFER: begin
          if (w_accept) begin
            if (w_more) begin
              r_out_data <= w_din_sel;
              r_cnt      <= r_cnt + CW'(1);
            end else begin
              r_out_valid <= 1'b0;
              r_ptr       <= r_out_sel + SEL_W'(1);
              r_state     <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign busy      = (r_state == XFER);

endmodule

// File: doc/mux8_rr_sched.md
# mux8_rr_sched

Round-robin scheduler that shares an 8-source, DW-bit selection datapath between eight independent requesters.
- Picks one requester, drives the 3-bit select (s2,s1,s0 order = out_sel[2:0]), registers the selected word and streams it to a single consumer over a valid/ready handshake.
- Bounded bursts per grant keep any single source from starving the rest.
- Sits between the eight producer ports and the downstream consumer of the muxed word.

## Interface
Parameters:
- DW, 3, data width per source
- BURST, 4, max beats per grant (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  8  req[i]=1: source i has a valid word on its din slice
- din  in  8*DW  source i word at din[i*DW +: DW]
- ack  out  8  one-hot; ack[i]=1 in the cycle whose rising edge captures din[i]; source advances its data on it
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts when out_valid&&out_ready
- out_data  out  DW  registered selected word
- out_sel  out  3  index of source that produced out_data
- busy  out  1  state==XFER

## Operation
- State machine with two states: IDLE and XFER. Pointer ptr[2:0] holds the search start index.
- IDLE:
  - if |req, winner = first i with req[i]=1, searching ptr, ptr+1, …, ptr+7 mod 8.
  - ack[winner]=1 that cycle.
  - On the edge: out_data←din[winner], out_sel←winner, out_valid←1, cnt←1, →XFER.
  - if no req: remain IDLE, ack=0.
- XFER:
  - out_data and out_sel are held stable while out_ready=0. No ack while stalled.
  - On accept, if req[out_sel]=1 and cnt<BURST:
    - ack[out_sel]=1, capture din[out_sel], cnt←cnt+1, stay in XFER. Beats are back-to-back with no bubble.
  - On accept otherwise:
    - out_valid←0, ptr←out_sel+1 (mod 8, 7 wraps to 0), →IDLE.
- Simultaneous requests are resolved only in IDLE. New requests during XFER wait.
- req[out_sel] dropping during XFER does not affect the already-captured beat; it ends the burst at that beat's accept.
- din/req of non-winning sources are ignored.
- ack is combinational from state, req, out_ready and ptr, and is forced to 0 while rst_n=0.
- cnt is sized clog2(BURST+1) bits, with no overflow past BURST.

## Timing
- Reset (async assert, sync-to-clk deassert expected externally): state=IDLE, ptr=0, cnt=0, out_valid=0, out_data=0, out_sel=0, busy=0, ack=0.
- Latency: req in IDLE at cycle n → out_valid=1 at cycle n+1.
- Inter-grant gap: exactly one cycle with out_valid=0 (the IDLE arbitration cycle).
- Throughput within a burst: 1 beat/cycle when out_ready=1.
- Reset mid-burst: all outputs return to reset values immediately. The in-flight beat is dropped and no ack is issued.

## Structure
- Package mux8_sched_pkg holds:
  - N_SRC=8 and SEL_W=3
  - state enum {IDLE, XFER}
- Sub-module rr_pick8 is combinational and is the only sub-module:
  - inputs req[7:0], ptr[2:0]
  - outputs found, idx[2:0]
  - implemented as a rotate, then a priority encode, then a rotate back
- The data select is an indexed part-select of din by winner/out_sel.

## Test plan
Default stimulus: din[i]=i (3'b000…3'b111), DW=3.
- Reset: rst_n=0, req=8'hFF, out_ready=1 → ack=0, out_valid=0, out_data=0 throughout; first grant one cycle after release goes to source 0.
- Single source: req=8'b0010_0000 for one beat, out_ready=1 → ack[5] pulse; next cycle out_valid=1, out_data=3'b101, out_sel=5; then IDLE, ptr=6.
- Fairness, BURST=1, req=8'hFF held, out_ready=1 → out_sel sequence 0,1,…,7,0; out_valid toggles 1,0 (one bubble per grant).
- Burst limit, BURST=4, req[2] and req[6] held → four back-to-back beats of 3'b010, bubble, then four of 3'b110, then 2 again.
- Backpressure: out_ready=0 for 5 cycles mid-burst → out_data/out_sel stable, ack=0, cnt unchanged; beats resume on out_ready=1.
- Reset mid-burst: assert rst_n=0 at beat 2 of a burst from source 3 → out_valid=0 same cycle; after release, arbitration restarts at ptr=0.
